ex_shift_stage: RTL and testbench
=================================

# ex_shift_stage

Two-stage pipelined execute-stage shift pipe for the MIPS core. It accepts decoded R-type shift instructions from the issue logic over a valid/ready handshake. It decodes the funct field into a shift mode and selects the shift amount source. It drives its own barrel shifter and delivers the result with its destination register tag to the EX/MEM write path. Latency is 2 cycles, with full throughput and backpressure support.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- TAG_W, 5, destination register tag width.

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  kill all in-flight entries (branch/exception redirect)
- in_valid  in  1  issue offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_funct  in  6  R-type funct field
- in_shamt  in  5  instruction shamt field
- in_rs  in  XLEN  rs operand (variable shift amount)
- in_rt  in  XLEN  rt operand (value shifted)
- in_rd  in  TAG_W  destination tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  shifted value
- out_rd  out  TAG_W  destination tag
- out_illegal  out  1  funct was not a shift
- busy  out  1  either pipeline stage holds a valid entry

## Operation
- Funct decode:
  - 000000 SLL: mode 00, amount {27'b0, shamt}
  - 000010 SRL: mode 01, amount {27'b0, shamt}
  - 000011 SRA: mode 10, amount {27'b0, shamt}
  - 000100 SLLV: mode 00, amount full in_rs
  - 000110 SRLV: mode 01, amount full in_rs
  - 000111 SRAV: mode 10, amount full in_rs
  - Any other funct: illegal; result forced to 32'h0 and out_illegal=1. The tag is still passed through.
- Shift semantics:
  - The value shifted is always in_rt.
  - If the amount is 0–31, shift by the amount.
  - If amount[31:5] is nonzero, the result saturates. It is all-ones when mode=10 and rt[31]=1, otherwise 32'h0. The full 32-bit rs amount is honoured, not truncated.
  - Logical right shift fills with 0. Arithmetic right shift fills with rt[31].
- Stage S1 registers the decoded mode, the 32-bit amount, rt, rd and the illegal flag.
- Stage S2 registers the shifter output, computed combinationally from the S1 registers, together with rd and the illegal flag.
- Handshake and advance rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv | flush
  - An input transfer occurs when in_valid & in_ready & !flush.
  - An output transfer occurs when out_valid & out_ready.
  - Bubbles collapse and results leave in issue order.
- Flush has priority over everything:
  - out_valid is forced low in the flush cycle, so no output transfer occurs.
  - Any input presented in that cycle is dropped.
  - s1_valid and s2_valid are 0 on the next edge.
- Payload registers update only on their stage's advance. They hold their value on stall and are don't-care when the stage is invalid.

## Timing
- Reset values:
  - s1_valid=0, s2_valid=0
  - out_valid=0, out_result=0, out_rd=0, out_illegal=0
  - busy=0
  - in_ready=1 while rst_n is low and after release
- Latency: an input accepted at edge N is presented on out_* after edge N+1, i.e. 2 cycles, provided out_ready stays high.
- Throughput: 1 per cycle when out_ready is held high.
- Under a sustained out_ready=0, exactly two entries are held, in S1 and S2. in_ready drops combinationally in the cycle both are valid.
- When out_ready goes high with both stages full, S2 drains and S1 moves into S2 on the same edge. A new input may be accepted on that same edge.
- out_* are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation clears both stages asynchronously. No partial result appears after rst_n deasserts.
- out_result, out_rd and out_illegal are direct register outputs with no combinational path from the inputs. in_ready and out_valid have combinational paths from out_ready and flush only.

## Structure
- Package mips_shift_pkg holds:
  - funct constants for the six shifts
  - a 2-bit shift-mode enum (SH_SLL=00, SH_SRL=01, SH_SRA=10)
  - XLEN and TAG_W defaults
- One sub-module, shift_barrel: purely combinational 32-bit log shifter. It has five 1/2/4/8/16 stages plus saturation on amount[31:5]≠0, and takes value, amount[31:0] and mode as inputs. The pipeline register and handshake logic stay in ex_shift_stage.
- Target size is about 200 lines of RTL in total.

## Test plan
- SRA, rt=32'h8000_0000, shamt=4, out_ready=1 → out_result=32'hF800_0000 two cycles after acceptance, out_illegal=0.
- SRAV rs=32'h20, rt=32'h8000_0001 → 32'hFFFF_FFFF. SRLV with the same operands → 32'h0. SLLV rs=32'h1F, rt=1 → 32'h8000_0000.
- Issue 3 back-to-back SLLs (rt=1, shamt=1/2/3) with out_ready=0:
  - in_ready falls after 2 are accepted.
  - Then raise out_ready → results 2, 4, 8 in order, and no loss or duplication.
- With both stages full, pulse flush for 1 cycle together with in_valid → out_valid=0 that cycle, busy=0 next cycle, and the offered input is never output.
- in_funct=6'h20, rd=7 → out_illegal=1, out_result=0, out_rd=7.
- Assert rst_n low while 2 entries are in flight → out_valid and busy are 0 immediately. After release, the first new SLL result appears with the normal 2-cycle latency.

Source files
------------

// File: rtl/mips_shift_pkg.sv
// Shared definitions for the execute-stage shift pipe: funct encodings,
// shift-mode enum, default widths and the funct decoder.
package mips_shift_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 5;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_mode_e;

    // use_rs selects the full rs register as the amount instead of shamt.
    typedef struct packed {
        shift_mode_e mode;
        logic        use_rs;
        logic        illegal;
    } shift_dec_t;

    function automatic shift_dec_t decode_funct(input logic [5:0] funct);
        shift_dec_t d;
        d.mode    = SH_SLL;
        d.use_rs  = 1'b0;
        d.illegal = 1'b0;
        case (funct)
            FUNCT_SLL:  d.mode = SH_SLL;
            FUNCT_SRL:  d.mode = SH_SRL;
            FUNCT_SRA:  d.mode = SH_SRA;
            FUNCT_SLLV: begin d.mode = SH_SLL; d.use_rs = 1'b1; end
            FUNCT_SRLV: begin d.mode = SH_SRL; d.use_rs = 1'b1; end
            FUNCT_SRAV: begin d.mode = SH_SRA; d.use_rs = 1'b1; end
            default:    d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/shift_barrel.sv
// Combinational 32-bit log shifter: five binary-weighted stages selected by
// amount[4:0], then saturation when any of amount[31:5] is set.
module shift_barrel
    import mips_shift_pkg::*;
(
    input  logic [31:0] value,
    input  logic [31:0] amount,
    input  shift_mode_e mode,
    output logic [31:0] result
);

    logic [31:0] staged;

    // Walk the 1/2/4/8/16 stages, then override with the saturated value
    // for amounts of 32 and above.
    always_comb begin
        staged = value;
        for (int i = 0; i < 5; i++) begin
            if (amount[i]) begin
                case (mode)
                    SH_SRL:  staged = staged >> (1 << i);
                    SH_SRA:  staged = $unsigned($signed(staged) >>> (1 << i));
                    default: staged = staged << (1 << i);
                endcase
            end
        end
        if (|amount[31:5]) begin
            result = (mode == SH_SRA && value[31]) ? '1 : '0;
        end else begin
            result = staged;
        end
    end

endmodule

// File: rtl/ex_shift_stage.sv
// Two-stage execute shift pipe. S1 holds the decoded operation, S2 holds the
// shifter result; both stages advance independently so bubbles collapse.
module ex_shift_stage
    import mips_shift_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_shamt,
    input  logic [XLEN-1:0]  in_rs,
    input  logic [XLEN-1:0]  in_rt,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_illegal,
    output logic             busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; a producer holds valid and payload stable until then.
    // Flush suppresses both transfers in its cycle and empties the pipe.

    shift_dec_t       dec;
    logic [XLEN-1:0]  dec_amount;
    logic             s1_valid, s2_valid;
    shift_mode_e      s1_mode;
    logic [XLEN-1:0]  s1_amount, s1_rt;
    logic [TAG_W-1:0] s1_rd;
    logic             s1_illegal;
    logic [XLEN-1:0]  s2_result;
    logic [TAG_W-1:0] s2_rd;
    logic             s2_illegal;
    logic [XLEN-1:0]  barrel_result;
    logic             s1_adv, s2_adv, accept;

    // Decode funct and pick the amount source for the incoming instruction.
    always_comb begin
        dec        = decode_funct(in_funct);
        dec_amount = dec.use_rs ? in_rs : {{(XLEN-5){1'b0}}, in_shamt};
    end

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv || flush;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = s2_valid && !flush;
    assign busy      = s1_valid || s2_valid;

    shift_barrel u_barrel (
        .value  (s1_rt),
        .amount (s1_amount),
        .mode   (s1_mode),
        .result (barrel_result)
    );

    // Stage valid bits: flush empties both, otherwise each follows its feeder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (s2_adv) s2_valid <= s1_valid;
        end
    end

    // S1 payload loads only on an accepted input and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_mode    <= SH_SLL;
            s1_amount  <= '0;
            s1_rt      <= '0;
            s1_rd      <= '0;
            s1_illegal <= 1'b0;
        end else if (accept) begin
            s1_mode    <= dec.mode;
            s1_amount  <= dec_amount;
            s1_rt      <= in_rt;
            s1_rd      <= in_rd;
            s1_illegal <= dec.illegal;
        end
    end

    // S2 payload captures the shifter output when S1 moves forward;
    // illegal operations produce a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_result  <= '0;
            s2_rd      <= '0;
            s2_illegal <= 1'b0;
        end else if (s2_adv && s1_valid && !flush) begin
            s2_result  <= s1_illegal ? '0 : barrel_result;
            s2_rd      <= s1_rd;
            s2_illegal <= s1_illegal;
        end
    end

    assign out_result  = s2_result;
    assign out_rd      = s2_rd;
    assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_ex_shift_stage.sv
// Self-checking bench for ex_shift_stage with a scoreboard of expected
// {illegal, rd, result} entries.
module tb_ex_shift_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_shamt = '0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [37:0] held_out = '0;
  logic        rand_done = 1'b0;

  ex_shift_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_shamt(in_shamt),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal),
    .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: {illegal, rd, result}
  function automatic logic [37:0] model(input logic [5:0] f, input logic [4:0] sh,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [4:0] rd);
    logic [31:0] amt;
    logic [1:0]  m;
    logic        ill;
    logic [31:0] res;
    logic [63:0] ext;
    amt = {27'b0, sh};
    m = 2'd0;
    ill = 1'b0;
    ext = '0;
    case (f)
      6'h00: m = 2'd0;
      6'h02: m = 2'd1;
      6'h03: m = 2'd2;
      6'h04: begin m = 2'd0; amt = rs; end
      6'h06: begin m = 2'd1; amt = rs; end
      6'h07: begin m = 2'd2; amt = rs; end
      default: ill = 1'b1;
    endcase
    if (ill) res = 32'h0;
    else if (amt > 32'd31) res = (m == 2'd2 && rt[31]) ? 32'hFFFF_FFFF : 32'h0;
    else begin
      case (m)
        2'd0: res = rt << amt[4:0];
        2'd1: res = rt >> amt[4:0];
        default: begin
          ext = {{32{rt[31]}}, rt} >> amt[4:0];
          res = ext[31:0];
        end
      endcase
    end
    return {ill, rd, res};
  endfunction

  // scoreboard monitor: sampled mid-cycle, inputs are driven just after posedge
  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst_n || flush) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid)
        check("stall_hold", {out_illegal, out_rd, out_result}, held_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("out_result", out_result, e[31:0]);
          check("out_rd", out_rd, e[36:32]);
          check("out_illegal", out_illegal, e[37]);
        end
      end
      prev_stall = out_valid && !out_ready;
      held_out = {out_illegal, out_rd, out_result};
      if (in_valid && in_ready)
        exp_q.push_back(model(in_funct, in_shamt, in_rs, in_rt, in_rd));
    end
  end

  // driver: offer one instruction and hold it until accepted
  task automatic set_in(input logic [5:0] f, input logic [4:0] sh,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    in_valid = 1'b1;
    in_funct = f;
    in_shamt = sh;
    in_rs = rs;
    in_rt = rt;
    in_rd = rd;
  endtask

  task automatic send(input logic [5:0] f, input logic [4:0] sh,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    logic acc;
    int   waits;
    set_in(f, sh, rs, rt, rd);
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
      waits++;
    end
    if (!acc) check("send_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // random out_ready backpressure during the random phase
  task automatic toggle_ready();
    while (!rand_done) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    out_ready = 1'b1;
  endtask

  task automatic random_sender();
    logic [5:0] fl[7];
    logic [5:0] f;
    logic [31:0] rs;
    fl = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h25};
    for (int i = 0; i < 60; i++) begin
      f = fl[$urandom_range(0, 6)];
      rs = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 40));
      send(f, 5'($urandom_range(0, 31)), rs, $urandom(), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_done = 1'b1;
  endtask

  initial begin
    // reset values, including while reset is held
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_illegal", out_illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // SRA latency: result appears after the second edge
    out_ready = 1'b1;
    send(6'h03, 5'd4, 32'h0, 32'h8000_0000, 5'd3);
    @(negedge clk);
    check("lat_not_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_valid", out_valid, 1);
    check("lat_result", out_result, 32'hF800_0000);
    check("lat_illegal", out_illegal, 0);
    idle(2);

    // variable shifts and saturation corners, back to back
    send(6'h07, 5'd0, 32'h20, 32'h8000_0001, 5'd1);
    send(6'h06, 5'd0, 32'h20, 32'h8000_0001, 5'd2);
    send(6'h04, 5'd0, 32'h1F, 32'h1, 5'd4);
    send(6'h07, 5'd0, 32'h100, 32'h7000_0000, 5'd5);
    send(6'h07, 5'd0, 32'h8000_0000, 32'h8000_0000, 5'd6);
    send(6'h06, 5'd0, 32'h1F, 32'hFFFF_FFFF, 5'd8);
    send(6'h00, 5'd0, 32'h0, 32'h1234_5678, 5'd9);
    send(6'h02, 5'd31, 32'h0, 32'h8000_0000, 5'd10);
    wait_drain();

    // backpressure: two held entries, in_ready drops, order kept on release
    out_ready = 1'b0;
    send(6'h00, 5'd1, 32'h0, 32'h1, 5'd11);
    send(6'h00, 5'd2, 32'h0, 32'h1, 5'd12);
    set_in(6'h00, 5'd3, 32'h0, 32'h1, 5'd13);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_head", out_result, 32'd2);
    idle(2);
    out_ready = 1'b1;
    send(6'h00, 5'd3, 32'h0, 32'h1, 5'd13);
    wait_drain();

    // flush with both stages full and an input offered
    out_ready = 1'b0;
    send(6'h00, 5'd4, 32'h0, 32'h1, 5'd14);
    send(6'h00, 5'd5, 32'h0, 32'h1, 5'd15);
    set_in(6'h00, 5'd6, 32'h0, 32'h1, 5'd31);
    flush = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_no_out", out_valid, 0);
    idle(4);

    // illegal funct keeps the tag
    send(6'h20, 5'd9, 32'h5, 32'hDEAD_BEEF, 5'd7);
    @(posedge clk);
    #1;
    check("ill_flag", out_illegal, 1);
    check("ill_result", out_result, 0);
    check("ill_rd", out_rd, 5'd7);
    wait_drain();

    // asynchronous reset with two entries in flight
    out_ready = 1'b0;
    send(6'h00, 5'd1, 32'h0, 32'h3, 5'd16);
    send(6'h00, 5'd2, 32'h0, 32'h3, 5'd17);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    check("post_rst_quiet", out_valid, 0);
    send(6'h00, 5'd2, 32'h0, 32'h5, 5'd18);
    @(negedge clk);
    check("post_rst_not_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_result", out_result, 32'd20);
    wait_drain();

    // random traffic with random backpressure
    fork
      random_sender();
      toggle_ready();
    join
    wait_drain();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
